// File: rtl/cache_miss_handler.sv
// cache_miss_handler
//   Sits between the direct-mapped data cache and the DDR2 controller. Accepts one
//   read-miss or write-through request at a time, issues a single-word command to
//   memory, waits (with a bounded timeout) for read data, then returns a one-cycle
//   response to the cache core together with a fill strobe for its data/tag RAM.
//
// Ports
//   clk, rst                    clock and asynchronous active-high reset
//   req_valid/ready/write/addr/wdata
//                               request from the cache core (accepted in IDLE only)
//   resp_valid/err/rdata        one-cycle completion pulse back to the cache core
//   fill_valid/addr/data        one-cycle write strobe into the cache line RAM
//   mem_cmd_valid/ready/write/addr/wdata
//                               single-word command toward the DDR2 controller
//   mem_rdata_valid/mem_rdata   read data return from the DDR2 controller
//
// All outputs are decoded from the state register and captured registers, so
// there is no combinational path from req_* or mem_* inputs to any output.
module cache_miss_handler #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_write,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    // Holds the store data for writes and the returned word for reads, so the
    // fill port and the command port share a single data register.
    logic [DATA_W-1:0] data_q,  data_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // State and captured-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_CMD;
                    write_d = req_write;
                    addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    data_d  = req_write ? req_wdata : '0;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (mem_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = write_q ? S_RESP : S_WAIT;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_WAIT: begin
                // Data arriving on the final wait cycle still beats the timeout.
                if (mem_rdata_valid) begin
                    data_d  = mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == LAST_WAIT) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic in_cmd_s;
    logic in_resp_s;
    assign in_cmd_s  = (state_q == S_CMD);
    assign in_resp_s = (state_q == S_RESP);

    assign req_ready     = (state_q == S_IDLE);

    assign mem_cmd_valid = in_cmd_s;
    assign mem_cmd_write = in_cmd_s & write_q;
    assign mem_cmd_addr  = in_cmd_s ? addr_q : '0;
    assign mem_cmd_wdata = (in_cmd_s && write_q) ? data_q : '0;

    assign resp_valid    = in_resp_s;
    assign resp_err      = in_resp_s & err_q;
    assign resp_rdata    = (in_resp_s && !err_q && !write_q) ? data_q : '0;

    // A timed-out read has no valid data, so the cache line is left untouched.
    assign fill_valid    = in_resp_s & ~err_q;
    assign fill_addr     = in_resp_s ? addr_q : '0;
    assign fill_data     = (in_resp_s && !err_q) ? data_q : '0;

endmodule
